// File: rtl/vlb_mshr_pkg.sv
// vlb_mshr_pkg: shared types for the VLB miss-status holding registers.
//   vpn_t       - virtual page number carried by a miss
//   mpn_t       - machine page number returned by the page-table walker
//   vlb_t       - entry index (wide enough for up to 8 entries)
//   ent_state_e - per-entry lifecycle: FREE -> PEND -> WALK -> FREE,
//                 with WALK -> DEAD when an in-flight walk is killed
//   oh2idx      - one-hot (up to 8 bits) to binary entry index
package vlb_mshr_pkg;

  localparam int VPN_W = 20;
  localparam int MPN_W = 16;
  localparam int VLB_W = 3;

  typedef logic [VPN_W-1:0] vpn_t;
  typedef logic [MPN_W-1:0] mpn_t;
  typedef logic [VLB_W-1:0] vlb_t;

  typedef enum logic [1:0] {
    ENT_FREE = 2'd0,
    ENT_PEND = 2'd1,
    ENT_WALK = 2'd2,
    ENT_DEAD = 2'd3
  } ent_state_e;

  function automatic vlb_t oh2idx(input logic [7:0] oh);
    vlb_t idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = vlb_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/vlb_mshr_prio.sv
// vlb_mshr_prio: lowest-index-first one-hot priority encoder.
//   req - request vector
//   gnt - one-hot grant of the lowest set bit of req (zero when req is zero)
//   any - at least one request bit set
module vlb_mshr_prio #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic         any
);

  // Two's-complement trick isolates the lowest set bit.
  assign gnt = req & (~req + {{(N-1){1'b0}}, 1'b1});
  assign any = |req;

endmodule

// File: rtl/vlb_mshr.sv
// vlb_mshr: miss-status holding registers between the VLB ports and the
// page-table walker. Misses are merged by vpn, walks are issued in entry
// order and completed walks are broadcast as single-cycle fills.
//
// Handshakes (req_i, ptw_req_o): a transfer happens on a rising edge where
// valid and ready are both 1. A source holding valid keeps its payload
// stable until the transfer. ptw_req_o is the exception allowed by kill_i:
// a kill withdraws valid without a transfer. ptw_resp_i and fill_o are
// valid-only (no backpressure).
//
// Ports:
//   clock, reset               - rising-edge clock, async active-high reset
//   req_i_*                    - miss request in (valid/ready, vpn)
//   ptw_req_o_*                - walk request out (valid/ready, idx, vpn)
//   ptw_resp_i_*               - walker response in (idx, vld, err, mpn, attr)
//   fill_o_*                   - fill broadcast out (vpn, vld, err, mpn, attr)
//   kill_i                     - bit0 drop PEND entries, bit1 also kill walks
//   busy_o                     - registered: some entry not FREE
//   dbg_state                  - entry i state at [2*i +: 2] (ent_state_e)
module vlb_mshr
  import vlb_mshr_pkg::*;
#(
  parameter int NUM_ENT = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req_i_valid,
  output logic                 req_i_ready,
  input  vpn_t                 req_i_bits_vpn,
  output logic                 ptw_req_o_valid,
  input  logic                 ptw_req_o_ready,
  output vlb_t                 ptw_req_o_bits_idx,
  output vpn_t                 ptw_req_o_bits_vpn,
  input  logic                 ptw_resp_i_valid,
  input  vlb_t                 ptw_resp_i_bits_idx,
  input  logic                 ptw_resp_i_bits_vld,
  input  logic                 ptw_resp_i_bits_err,
  input  mpn_t                 ptw_resp_i_bits_mpn,
  input  logic [3:0]           ptw_resp_i_bits_attr,
  output logic                 fill_o_valid,
  output vpn_t                 fill_o_bits_vpn,
  output logic                 fill_o_bits_vld,
  output logic                 fill_o_bits_err,
  output mpn_t                 fill_o_bits_mpn,
  output logic [3:0]           fill_o_bits_attr,
  input  logic [1:0]           kill_i,
  output logic                 busy_o,
  output logic [2*NUM_ENT-1:0] dbg_state
);

  ent_state_e st_q [NUM_ENT];
  ent_state_e st_d [NUM_ENT];
  vpn_t       vpn_q[NUM_ENT];
  vpn_t       vpn_d[NUM_ENT];

  logic [NUM_ENT-1:0] free_vec, hit_vec, resp_hit, alloc_oh, pend_nxt, pend_oh;
  logic free_any, pend_any, accept, merge, issue, fill_d, busy_d;
  vpn_t fill_vpn_d, pend_vpn;
  vlb_t pend_idx;

  // Current-state decode.
  always_comb begin
    free_vec   = '0;
    hit_vec    = '0;
    resp_hit   = '0;
    fill_d     = 1'b0;
    fill_vpn_d = '0;
    for (int i = 0; i < NUM_ENT; i++) begin
      free_vec[i] = (st_q[i] == ENT_FREE);
      hit_vec[i]  = (st_q[i] == ENT_PEND || st_q[i] == ENT_WALK) &&
                    (vpn_q[i] == req_i_bits_vpn);
      resp_hit[i] = ptw_resp_i_valid && (ptw_resp_i_bits_idx == vlb_t'(i));
      if (resp_hit[i] && st_q[i] == ENT_WALK) begin
        fill_d     = 1'b1;
        fill_vpn_d = vpn_q[i];
      end
    end
  end

  vlb_mshr_prio #(.N(NUM_ENT)) u_alloc_prio (
    .req (free_vec),
    .gnt (alloc_oh),
    .any (free_any)
  );

  assign req_i_ready = free_any && (kill_i == 2'b00) && !reset;
  assign accept      = req_i_valid && req_i_ready;
  // An entry being completed this cycle is still WALK, so it is covered
  // by the merge match and its fill serves the new request too.
  assign merge       = |hit_vec;
  assign issue       = ptw_req_o_valid && ptw_req_o_ready && (kill_i == 2'b00);

  // Per-entry next state.
  always_comb begin
    pend_nxt = '0;
    for (int i = 0; i < NUM_ENT; i++) begin
      st_d[i]  = st_q[i];
      vpn_d[i] = vpn_q[i];
      unique case (st_q[i])
        ENT_FREE: begin
          if (accept && !merge && alloc_oh[i]) begin
            st_d[i]  = ENT_PEND;
            vpn_d[i] = req_i_bits_vpn;
          end
        end
        ENT_PEND: begin
          if (kill_i != 2'b00) st_d[i] = ENT_FREE;
          else if (issue && ptw_req_o_bits_idx == vlb_t'(i)) st_d[i] = ENT_WALK;
        end
        ENT_WALK: begin
          // A response in the same cycle as a walk kill still completes.
          if (resp_hit[i]) st_d[i] = ENT_FREE;
          else if (kill_i[1]) st_d[i] = ENT_DEAD;
        end
        ENT_DEAD: begin
          if (resp_hit[i]) st_d[i] = ENT_FREE;
        end
      endcase
      pend_nxt[i] = (st_d[i] == ENT_PEND);
    end
  end

  vlb_mshr_prio #(.N(NUM_ENT)) u_pend_prio (
    .req (pend_nxt),
    .gnt (pend_oh),
    .any (pend_any)
  );

  always_comb begin
    pend_vpn  = '0;
    busy_d    = 1'b0;
    dbg_state = '0;
    for (int i = 0; i < NUM_ENT; i++) begin
      if (pend_oh[i]) pend_vpn = vpn_d[i];
      if (st_d[i] != ENT_FREE) busy_d = 1'b1;
      dbg_state[2*i +: 2] = st_q[i];
    end
    pend_idx = oh2idx(8'(pend_oh));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_ENT; i++) begin
        st_q[i]  <= ENT_FREE;
        vpn_q[i] <= '0;
      end
      ptw_req_o_valid    <= 1'b0;
      ptw_req_o_bits_idx <= '0;
      ptw_req_o_bits_vpn <= '0;
      fill_o_valid       <= 1'b0;
      fill_o_bits_vpn    <= '0;
      fill_o_bits_vld    <= 1'b0;
      fill_o_bits_err    <= 1'b0;
      fill_o_bits_mpn    <= '0;
      fill_o_bits_attr   <= '0;
      busy_o             <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_ENT; i++) begin
        st_q[i]  <= st_d[i];
        vpn_q[i] <= vpn_d[i];
      end
      // Hold the presented walk while stalled; a kill withdraws it.
      if (kill_i != 2'b00) begin
        ptw_req_o_valid <= 1'b0;
      end else if (!(ptw_req_o_valid && !ptw_req_o_ready)) begin
        ptw_req_o_valid    <= pend_any;
        ptw_req_o_bits_idx <= pend_idx;
        ptw_req_o_bits_vpn <= pend_vpn;
      end
      fill_o_valid <= fill_d;
      if (fill_d) begin
        fill_o_bits_vpn  <= fill_vpn_d;
        fill_o_bits_vld  <= ptw_resp_i_bits_vld;
        fill_o_bits_err  <= ptw_resp_i_bits_err;
        fill_o_bits_mpn  <= ptw_resp_i_bits_mpn;
        fill_o_bits_attr <= ptw_resp_i_bits_attr;
      end
      busy_o <= busy_d;
    end
  end

endmodule

// File: tb/tb_vlb_mshr.sv
// tb_vlb_mshr: directed scenarios followed by randomized traffic, every
// cycle compared against a slot-level reference model of outstanding misses.
module tb_vlb_mshr;
  import vlb_mshr_pkg::*;

  localparam int N = 4;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic         req_i_valid, req_i_ready;
  vpn_t         req_i_bits_vpn;
  logic         ptw_req_o_valid, ptw_req_o_ready;
  vlb_t         ptw_req_o_bits_idx;
  vpn_t         ptw_req_o_bits_vpn;
  logic         ptw_resp_i_valid, ptw_resp_i_bits_vld, ptw_resp_i_bits_err;
  vlb_t         ptw_resp_i_bits_idx;
  mpn_t         ptw_resp_i_bits_mpn;
  logic [3:0]   ptw_resp_i_bits_attr;
  logic         fill_o_valid, fill_o_bits_vld, fill_o_bits_err;
  vpn_t         fill_o_bits_vpn;
  mpn_t         fill_o_bits_mpn;
  logic [3:0]   fill_o_bits_attr;
  logic [1:0]   kill_i;
  logic         busy_o;
  logic [2*N-1:0] dbg_state;

  vlb_mshr #(.NUM_ENT(N)) dut (
    .clock                (clock),
    .reset                (reset),
    .req_i_valid          (req_i_valid),
    .req_i_ready          (req_i_ready),
    .req_i_bits_vpn       (req_i_bits_vpn),
    .ptw_req_o_valid      (ptw_req_o_valid),
    .ptw_req_o_ready      (ptw_req_o_ready),
    .ptw_req_o_bits_idx   (ptw_req_o_bits_idx),
    .ptw_req_o_bits_vpn   (ptw_req_o_bits_vpn),
    .ptw_resp_i_valid     (ptw_resp_i_valid),
    .ptw_resp_i_bits_idx  (ptw_resp_i_bits_idx),
    .ptw_resp_i_bits_vld  (ptw_resp_i_bits_vld),
    .ptw_resp_i_bits_err  (ptw_resp_i_bits_err),
    .ptw_resp_i_bits_mpn  (ptw_resp_i_bits_mpn),
    .ptw_resp_i_bits_attr (ptw_resp_i_bits_attr),
    .fill_o_valid         (fill_o_valid),
    .fill_o_bits_vpn      (fill_o_bits_vpn),
    .fill_o_bits_vld      (fill_o_bits_vld),
    .fill_o_bits_err      (fill_o_bits_err),
    .fill_o_bits_mpn      (fill_o_bits_mpn),
    .fill_o_bits_attr     (fill_o_bits_attr),
    .kill_i               (kill_i),
    .busy_o               (busy_o),
    .dbg_state            (dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int passes = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Each slot is either unused, waiting to be walked, being walked, or
  // abandoned (walk killed, waiting for the walker to answer).
  bit   m_used[N], m_walk[N], m_dead[N];
  vpn_t m_vpn[N];
  bit   m_pv;
  int   m_pidx;
  bit   m_fv, m_fvld, m_ferr;
  vpn_t m_fvpn;
  mpn_t m_fmpn;
  logic [3:0] m_fattr;
  bit   m_busy;
  int   walk_cnt = 0;
  int   fill_cnt = 0;
  int   walk_q[$];

  function automatic bit m_ready();
    bit any_free;
    any_free = 0;
    for (int i = 0; i < N; i++) if (!m_used[i]) any_free = 1;
    return any_free && (kill_i == 2'b00) && !reset;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_used[i] = 0; m_walk[i] = 0; m_dead[i] = 0; m_vpn[i] = '0;
    end
    m_pv = 0; m_pidx = 0; m_fv = 0; m_busy = 0;
    walk_q.delete();
  endtask

  // Advances the model across one rising edge using the inputs now driven.
  task automatic model_edge();
    bit pu[N], pw[N], pd[N];
    vpn_t pvpn[N];
    bit acc, mrg, iss;
    int slot, k;
    pu = m_used; pw = m_walk; pd = m_dead; pvpn = m_vpn;
    acc = req_i_valid && m_ready();
    iss = m_pv && ptw_req_o_ready && (kill_i == 2'b00);
    m_fv = 0;
    if (ptw_resp_i_valid && int'(ptw_resp_i_bits_idx) < N) begin
      k = int'(ptw_resp_i_bits_idx);
      if (pu[k] && pw[k]) begin
        m_fv = 1; m_fvpn = pvpn[k]; m_fmpn = ptw_resp_i_bits_mpn;
        m_fvld = ptw_resp_i_bits_vld; m_ferr = ptw_resp_i_bits_err;
        m_fattr = ptw_resp_i_bits_attr;
        m_used[k] = 0; m_walk[k] = 0;
      end else if (pu[k] && pd[k]) begin
        m_used[k] = 0; m_dead[k] = 0;
      end
    end
    mrg = 0;
    for (int i = 0; i < N; i++) if (pu[i] && !pd[i] && pvpn[i] == req_i_bits_vpn) mrg = 1;
    slot = -1;
    for (int i = 0; i < N; i++) if (!pu[i] && slot < 0) slot = i;
    if (iss) begin
      m_walk[m_pidx] = 1;
      walk_q.push_back(m_pidx);
    end
    for (int i = 0; i < N; i++)
      if (pu[i] && !pw[i] && !pd[i] && kill_i != 2'b00) m_used[i] = 0;
    if (kill_i[1])
      for (int i = 0; i < N; i++)
        if (m_used[i] && m_walk[i]) begin m_walk[i] = 0; m_dead[i] = 1; end
    if (acc && !mrg) begin
      m_used[slot] = 1; m_walk[slot] = 0; m_dead[slot] = 0; m_vpn[slot] = req_i_bits_vpn;
    end
    if (kill_i != 2'b00) m_pv = 0;
    else if (!(m_pv && !ptw_req_o_ready)) begin
      m_pv = 0;
      for (int i = N - 1; i >= 0; i--)
        if (m_used[i] && !m_walk[i] && !m_dead[i]) begin m_pv = 1; m_pidx = i; end
    end
    m_busy = 0;
    for (int i = 0; i < N; i++) if (m_used[i]) m_busy = 1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    req_i_valid = 0; req_i_bits_vpn = '0; ptw_req_o_ready = 0;
    ptw_resp_i_valid = 0; ptw_resp_i_bits_idx = '0; ptw_resp_i_bits_vld = 0;
    ptw_resp_i_bits_err = 0; ptw_resp_i_bits_mpn = '0; ptw_resp_i_bits_attr = '0;
    kill_i = 2'b00;
  endtask

  task automatic rand_resp_fields();
    ptw_resp_i_bits_vld  = 1'($urandom);
    ptw_resp_i_bits_err  = 1'($urandom);
    ptw_resp_i_bits_mpn  = mpn_t'($urandom);
    ptw_resp_i_bits_attr = 4'($urandom);
  endtask

  // One clock cycle: check ready, advance the model, check registered outputs.
  task automatic cyc();
    #1;
    chk("req_ready", req_i_ready, m_ready());
    if (ptw_req_o_valid && ptw_req_o_ready && kill_i == 2'b00) walk_cnt++;
    model_edge();
    @(posedge clock);
    #1;
    chk("ptw_valid", ptw_req_o_valid, m_pv);
    if (m_pv) begin
      chk("ptw_idx", ptw_req_o_bits_idx, m_pidx);
      chk("ptw_vpn", ptw_req_o_bits_vpn, m_vpn[m_pidx]);
    end
    chk("fill_valid", fill_o_valid, m_fv);
    if (m_fv) begin
      chk("fill_vpn", fill_o_bits_vpn, m_fvpn);
      chk("fill_mpn", fill_o_bits_mpn, m_fmpn);
      chk("fill_vld", fill_o_bits_vld, m_fvld);
      chk("fill_err", fill_o_bits_err, m_ferr);
      chk("fill_attr", fill_o_bits_attr, m_fattr);
    end
    if (fill_o_valid) fill_cnt++;
    chk("busy", busy_o, m_busy);
  endtask

  task automatic do_reset();
    #2;
    reset = 1;
    #1;
    chk("rst_ready", req_i_ready, 0);
    chk("rst_ptw_valid", ptw_req_o_valid, 0);
    chk("rst_ptw_idx", ptw_req_o_bits_idx, 0);
    chk("rst_ptw_vpn", ptw_req_o_bits_vpn, 0);
    chk("rst_fill_valid", fill_o_valid, 0);
    chk("rst_fill_vpn", fill_o_bits_vpn, 0);
    chk("rst_fill_mpn", fill_o_bits_mpn, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_state", dbg_state, 0);
    model_clear();
    idle();
    @(posedge clock);
    #1;
    reset = 0;
    #1;
    chk("ready_after_reset", req_i_ready, 1);
  endtask

  task automatic drain();
    idle();
    ptw_req_o_ready = 1;
    for (int t = 0; t < 40; t++) begin
      ptw_resp_i_valid = 0;
      if (walk_q.size() > 0) begin
        ptw_resp_i_valid    = 1;
        ptw_resp_i_bits_idx = vlb_t'(walk_q.pop_front());
        rand_resp_fields();
      end
      cyc();
    end
    idle();
    chk("drain_busy", busy_o, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int wc0, fc0, j;
    reset = 1;
    idle();
    model_clear();
    repeat (2) @(posedge clock);
    #1;
    chk("in_reset_ready", req_i_ready, 0);
    chk("in_reset_ptw_valid", ptw_req_o_valid, 0);
    chk("in_reset_busy", busy_o, 0);
    reset = 0;
    #1;
    chk("first_ready", req_i_ready, 1);

    // Single miss: walk next cycle, fill one cycle after the response.
    idle();
    req_i_valid = 1; req_i_bits_vpn = 20'h00123; ptw_req_o_ready = 1;
    cyc();
    chk("s1_ptw_valid", ptw_req_o_valid, 1);
    chk("s1_ptw_idx", ptw_req_o_bits_idx, 0);
    chk("s1_ptw_vpn", ptw_req_o_bits_vpn, 20'h00123);
    req_i_valid = 0;
    cyc();
    ptw_resp_i_valid = 1; ptw_resp_i_bits_idx = 3'd0; ptw_resp_i_bits_mpn = 16'h0045;
    ptw_resp_i_bits_vld = 1; ptw_resp_i_bits_err = 0; ptw_resp_i_bits_attr = 4'h3;
    void'(walk_q.pop_front());
    cyc();
    chk("s1_fill_valid", fill_o_valid, 1);
    chk("s1_fill_vpn", fill_o_bits_vpn, 20'h00123);
    chk("s1_fill_mpn", fill_o_bits_mpn, 16'h0045);
    chk("s1_fill_vld", fill_o_bits_vld, 1);
    ptw_resp_i_valid = 0;
    cyc();
    chk("s1_fill_pulse", fill_o_valid, 0);
    chk("s1_busy", busy_o, 0);

    // Fill every entry with the walker stalled.
    idle();
    for (int k = 0; k < 4; k++) begin
      req_i_valid = 1; req_i_bits_vpn = vpn_t'(16 * (k + 1));
      cyc();
    end
    chk("s2_full_ready", req_i_ready, 0);
    req_i_bits_vpn = 20'h00999;
    repeat (2) cyc();
    req_i_bits_vpn = 20'h00010;
    repeat (2) cyc();
    chk("s2_dup_stall", req_i_ready, 0);
    chk("s2_busy", busy_o, 1);
    req_i_valid = 0; ptw_req_o_ready = 1;
    cyc();
    ptw_req_o_ready = 0;
    ptw_resp_i_valid = 1; ptw_resp_i_bits_idx = 3'd0; rand_resp_fields();
    void'(walk_q.pop_front());
    cyc();
    chk("s2_fill_valid", fill_o_valid, 1);
    chk("s2_fill_vpn", fill_o_bits_vpn, 20'h00010);
    chk("s2_ready_again", req_i_ready, 1);
    drain();

    // Back-to-back duplicate misses merge into one walk.
    idle();
    wc0 = walk_cnt; fc0 = fill_cnt;
    req_i_valid = 1; req_i_bits_vpn = 20'h00200;
    cyc();
    cyc();
    drain();
    chk("s3_walks", walk_cnt - wc0, 1);
    chk("s3_fills", fill_cnt - fc0, 1);

    // Kill an in-flight walk, then let its response arrive.
    idle();
    fc0 = fill_cnt;
    req_i_valid = 1; req_i_bits_vpn = 20'h00300; ptw_req_o_ready = 1;
    cyc();
    req_i_valid = 0;
    cyc();
    ptw_req_o_ready = 0; kill_i = 2'b10;
    cyc();
    chk("s4_dead", dbg_state[1:0], ENT_DEAD);
    kill_i = 2'b00;
    ptw_resp_i_valid = 1; ptw_resp_i_bits_idx = 3'd0; rand_resp_fields();
    void'(walk_q.pop_front());
    cyc();
    ptw_resp_i_valid = 0;
    chk("s4_no_fill", fill_o_valid, 0);
    chk("s4_free", dbg_state[1:0], ENT_FREE);
    chk("s4_busy", busy_o, 0);
    cyc();
    chk("s4_fill_cnt", fill_cnt - fc0, 0);

    // Kill an unissued miss while the walker is stalled.
    idle();
    wc0 = walk_cnt;
    req_i_valid = 1; req_i_bits_vpn = 20'h00400;
    cyc();
    chk("s5_ptw_valid", ptw_req_o_valid, 1);
    req_i_valid = 0; kill_i = 2'b01;
    cyc();
    chk("s5_ptw_dropped", ptw_req_o_valid, 0);
    kill_i = 2'b00; ptw_req_o_ready = 1;
    repeat (3) cyc();
    chk("s5_no_walk", walk_cnt - wc0, 0);
    chk("s5_busy", busy_o, 0);

    // Reset with two walks outstanding; the late response must be ignored.
    idle();
    ptw_req_o_ready = 1;
    req_i_valid = 1; req_i_bits_vpn = 20'h00500;
    cyc();
    req_i_bits_vpn = 20'h00600;
    cyc();
    req_i_valid = 0;
    cyc();
    chk("s6_two_walks", dbg_state[3:0], {ENT_WALK, ENT_WALK});
    do_reset();
    ptw_resp_i_valid = 1; ptw_resp_i_bits_idx = 3'd1; rand_resp_fields();
    cyc();
    chk("s6_late_resp", fill_o_valid, 0);
    idle();

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      req_i_valid     = 1'($urandom);
      req_i_bits_vpn  = 20'h00700 + vpn_t'($urandom_range(0, 5));
      ptw_req_o_ready = ($urandom_range(0, 3) != 0);
      kill_i          = ($urandom_range(0, 39) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      ptw_resp_i_valid = 0;
      if (walk_q.size() > 0 && $urandom_range(0, 2) == 0) begin
        j = $urandom_range(0, walk_q.size() - 1);
        ptw_resp_i_valid    = 1;
        ptw_resp_i_bits_idx = vlb_t'(walk_q[j]);
        walk_q.delete(j);
        rand_resp_fields();
      end else if ($urandom_range(0, 19) == 0) begin
        ptw_resp_i_valid    = 1;
        ptw_resp_i_bits_idx = vlb_t'($urandom_range(0, 7));
        rand_resp_fields();
      end
      if ($urandom_range(0, 499) == 0) do_reset();
      else cyc();
    end
    drain();

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
